// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32 decode stage with handshake, load-use stall,
// write-back bypass, in-ID jump resolution and ID/EX pipeline register.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   IF/ID handshake (pipe_pc, pipe_pc4, pipe_data)
//   flush                 kills the ID/EX entry and the current input
//   ex_ready              EX consumes the ID/EX entry this cycle
//   op_write/write_*      write-back port, bypassed into operand reads
//   write_pc_reg_*        regfile write pass-through (x0 writes masked)
//   load_pc_reg_*         regfile read addresses / same-cycle read data
//   control_j / pc_j      registered redirect pulse and jump target
//   out_valid ... illegal ID/EX pipeline register contents
module id_stage_pipe #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     RA_W      = 5,
    parameter logic [XLEN-1:0] RESET_PC4 = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pipe_pc,
    input  logic [XLEN-1:0] pipe_pc4,
    input  logic [31:0]     pipe_data,
    input  logic            flush,
    input  logic            ex_ready,
    input  logic            op_write,
    input  logic [RA_W-1:0] write_addr,
    input  logic [XLEN-1:0] write_data,
    output logic            write_pc_reg_we,
    output logic [RA_W-1:0] write_pc_reg_addr,
    output logic [XLEN-1:0] write_pc_reg_value,
    output logic [RA_W-1:0] load_pc_reg_addr1,
    output logic [RA_W-1:0] load_pc_reg_addr2,
    input  logic [XLEN-1:0] load_pc_reg_value1,
    input  logic [XLEN-1:0] load_pc_reg_value2,
    output logic            control_j,
    output logic [XLEN-1:0] pc_j,
    output logic            out_valid,
    output logic [8:0]      ctrl_ex,
    output logic            branch_ex,
    output logic [XLEN-1:0] pc_ex,
    output logic [XLEN-1:0] pc4_ex,
    output logic [XLEN-1:0] r_data1,
    output logic [XLEN-1:0] r_data2,
    output logic [XLEN-1:0] extended,
    output logic [RA_W-1:0] rd_ex,
    output logic            illegal
);

    typedef enum logic {RUN, DROP} state_e;

    localparam logic [6:0] OP_R    = 7'h33;
    localparam logic [6:0] OP_I    = 7'h13;
    localparam logic [6:0] OP_LD   = 7'h03;
    localparam logic [6:0] OP_SD   = 7'h23;
    localparam logic [6:0] OP_BR   = 7'h63;
    localparam logic [6:0] OP_JAL  = 7'h6F;
    localparam logic [6:0] OP_JALR = 7'h67;

    state_e          state_q;
    logic            out_valid_q;
    logic [8:0]      ctrl_q;
    logic            branch_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc4_q;
    logic [XLEN-1:0] r1_q;
    logic [XLEN-1:0] r2_q;
    logic [XLEN-1:0] ext_q;
    logic [RA_W-1:0] rd_q;
    logic            illegal_q;
    logic            control_j_q;
    logic [XLEN-1:0] pc_j_q;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;

    assign opcode = pipe_data[6:0];
    assign funct3 = pipe_data[14:12];
    assign rs1    = RA_W'(pipe_data[19:15]);
    assign rs2    = RA_W'(pipe_data[24:20]);
    assign rd     = RA_W'(pipe_data[11:7]);

    assign imm_i = {{(XLEN-12){pipe_data[31]}}, pipe_data[31:20]};
    assign imm_s = {{(XLEN-12){pipe_data[31]}},
                    pipe_data[31:25], pipe_data[11:7]};
    assign imm_b = {{(XLEN-13){pipe_data[31]}}, pipe_data[31],
                    pipe_data[7], pipe_data[30:25],
                    pipe_data[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){pipe_data[31]}}, pipe_data[31],
                    pipe_data[19:12], pipe_data[20],
                    pipe_data[30:21], 1'b0};

    // Register file write pass-through; x0 is never written.
    assign write_pc_reg_we    = op_write & (write_addr != '0);
    assign write_pc_reg_addr  = write_addr;
    assign write_pc_reg_value = write_data;

    assign load_pc_reg_addr1 = rs1;
    assign load_pc_reg_addr2 = rs2;

    // Operand read with write-back bypass; x0 always reads 0.
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    always_comb begin
        op1 = load_pc_reg_value1;
        if (rs1 == '0) begin
            op1 = '0;
        end else if (op_write && write_addr == rs1) begin
            op1 = write_data;
        end
    end

    always_comb begin
        op2 = load_pc_reg_value2;
        if (rs2 == '0) begin
            op2 = '0;
        end else if (op_write && write_addr == rs2) begin
            op2 = write_data;
        end
    end

    // Decoder
    logic            is_r;
    logic            is_i;
    logic            is_ld;
    logic            is_sd;
    logic            is_br;
    logic            is_jal;
    logic            is_jalr;
    logic [8:0]      dec_ctrl;
    logic            dec_br;
    logic            dec_ill;
    logic [XLEN-1:0] dec_imm;
    logic [RA_W-1:0] dec_rd;
    logic            uses_rs2;
    logic [2:0]      alu_r;

    assign is_r    = (opcode == OP_R);
    assign is_i    = (opcode == OP_I);
    assign is_ld   = (opcode == OP_LD);
    assign is_sd   = (opcode == OP_SD);
    assign is_br   = (opcode == OP_BR);
    assign is_jal  = (opcode == OP_JAL);
    assign is_jalr = (opcode == OP_JALR);

    always_comb begin
        alu_r = 3'b000;
        case (funct3)
            3'b000:  alu_r = pipe_data[30] ? 3'b001 : 3'b000;
            3'b001:  alu_r = 3'b100;
            3'b010:  alu_r = 3'b101;
            3'b110:  alu_r = 3'b011;
            3'b111:  alu_r = 3'b010;
            default: alu_r = 3'b000;
        endcase
    end

    always_comb begin
        dec_ctrl = '0;
        dec_br   = 1'b0;
        dec_ill  = 1'b0;
        dec_imm  = '0;
        dec_rd   = rd;
        uses_rs2 = 1'b0;
        unique case (1'b1)
            is_r: begin
                dec_ctrl = {3'b100, 2'b00, alu_r, 1'b0};
                uses_rs2 = 1'b1;
            end
            is_i: begin
                dec_ctrl = 9'b100_00_0001;
                dec_imm  = imm_i;
            end
            is_ld: begin
                dec_ctrl = 9'b101_10_0001;
                dec_imm  = imm_i;
            end
            is_sd: begin
                dec_ctrl = 9'b000_01_0001;
                dec_imm  = imm_s;
                dec_rd   = '0;
                uses_rs2 = 1'b1;
            end
            is_br: begin
                dec_br   = 1'b1;
                dec_imm  = imm_b;
                dec_rd   = '0;
                uses_rs2 = 1'b1;
            end
            is_jal: begin
                dec_ctrl = 9'b110_00_0000;
                dec_imm  = imm_j;
            end
            is_jalr: begin
                dec_ctrl = 9'b110_00_0000;
                dec_imm  = imm_i;
            end
            default: begin
                dec_ill = 1'b1;
                dec_rd  = '0;
            end
        endcase
    end

    // JALR uses the bypassed rs1; bit 0 of the target is cleared.
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jump_tgt;

    assign jalr_sum = op1 + imm_i;
    assign jump_tgt = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0}
                              : pipe_pc + imm_j;

    // A load in ID/EX whose result is needed now holds the input.
    logic load_use;
    logic accept;

    assign load_use = out_valid_q & ctrl_q[5] & (rd_q != '0) &
                      ((rd_q == rs1) | ((rd_q == rs2) & uses_rs2));
    assign in_ready = ~reset & ~load_use & (~out_valid_q | ex_ready);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            branch_q    <= 1'b0;
            pc_q        <= '0;
            pc4_q       <= RESET_PC4;
            r1_q        <= '0;
            r2_q        <= '0;
            ext_q       <= '0;
            rd_q        <= '0;
            illegal_q   <= 1'b0;
            control_j_q <= 1'b0;
            pc_j_q      <= '0;
        end else begin
            control_j_q <= 1'b0;
            if (flush) begin
                out_valid_q <= 1'b0;
                state_q     <= RUN;
            end else if (accept && state_q == RUN) begin
                out_valid_q <= 1'b1;
                ctrl_q      <= dec_ctrl;
                branch_q    <= dec_br;
                pc_q        <= pipe_pc;
                pc4_q       <= pipe_pc4;
                r1_q        <= op1;
                r2_q        <= op2;
                ext_q       <= dec_imm;
                rd_q        <= dec_rd;
                illegal_q   <= dec_ill;
                if (is_jal || is_jalr) begin
                    control_j_q <= 1'b1;
                    pc_j_q      <= jump_tgt;
                    state_q     <= DROP;
                end
            end else if (accept) begin
                // Wrong-path slot after a jump: consume, do not load.
                state_q <= RUN;
                if (ex_ready) begin
                    out_valid_q <= 1'b0;
                end
            end else if (ex_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign ctrl_ex   = ctrl_q;
    assign branch_ex = branch_q;
    assign pc_ex     = pc_q;
    assign pc4_ex    = pc4_q;
    assign r_data1   = r1_q;
    assign r_data2   = r2_q;
    assign extended  = ext_q;
    assign rd_ex     = rd_q;
    assign illegal   = illegal_q;
    assign control_j = control_j_q;
    assign pc_j      = pc_j_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: scoreboard bench for id_stage_pipe.
// Expected ID/EX entries are queued on accept and checked on consume.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] pipe_pc = '0;
    logic [31:0] pipe_pc4 = '0;
    logic [31:0] pipe_data = '0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b1;
    logic        op_write = 1'b0;
    logic [4:0]  write_addr = '0;
    logic [31:0] write_data = '0;
    logic        write_pc_reg_we;
    logic [4:0]  write_pc_reg_addr;
    logic [31:0] write_pc_reg_value;
    logic [4:0]  load_pc_reg_addr1;
    logic [4:0]  load_pc_reg_addr2;
    logic [31:0] load_pc_reg_value1;
    logic [31:0] load_pc_reg_value2;
    logic        control_j;
    logic [31:0] pc_j;
    logic        out_valid;
    logic [8:0]  ctrl_ex;
    logic        branch_ex;
    logic [31:0] pc_ex;
    logic [31:0] pc4_ex;
    logic [31:0] r_data1;
    logic [31:0] r_data2;
    logic [31:0] extended;
    logic [4:0]  rd_ex;
    logic        illegal;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .pipe_pc(pipe_pc),
        .pipe_pc4(pipe_pc4),
        .pipe_data(pipe_data),
        .flush(flush),
        .ex_ready(ex_ready),
        .op_write(op_write),
        .write_addr(write_addr),
        .write_data(write_data),
        .write_pc_reg_we(write_pc_reg_we),
        .write_pc_reg_addr(write_pc_reg_addr),
        .write_pc_reg_value(write_pc_reg_value),
        .load_pc_reg_addr1(load_pc_reg_addr1),
        .load_pc_reg_addr2(load_pc_reg_addr2),
        .load_pc_reg_value1(load_pc_reg_value1),
        .load_pc_reg_value2(load_pc_reg_value2),
        .control_j(control_j),
        .pc_j(pc_j),
        .out_valid(out_valid),
        .ctrl_ex(ctrl_ex),
        .branch_ex(branch_ex),
        .pc_ex(pc_ex),
        .pc4_ex(pc4_ex),
        .r_data1(r_data1),
        .r_data2(r_data2),
        .extended(extended),
        .rd_ex(rd_ex),
        .illegal(illegal)
    );

    // Register file stub
    logic [31:0] rf [32];
    assign load_pc_reg_value1 = rf[load_pc_reg_addr1];
    assign load_pc_reg_value2 = rf[load_pc_reg_addr2];

    typedef struct {
        logic [8:0]  ctrl;
        logic        br;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] ext;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rfv(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : rf[a];
    endfunction

    function automatic exp_t mk(input logic [8:0] c, input logic b,
                                input logic [31:0] ins,
                                input logic [31:0] pc,
                                input logic [31:0] ext,
                                input logic [4:0] rd,
                                input logic ill);
        exp_t e;
        e.ctrl = c;
        e.br   = b;
        e.pc   = pc;
        e.pc4  = pc + 32'd4;
        e.r1   = rfv(ins[19:15]);
        e.r2   = rfv(ins[24:20]);
        e.ext  = ext;
        e.rd   = rd;
        e.ill  = ill;
        return e;
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1,
                                          input int f3, input int rd,
                                          input int op);
        logic [11:0] im;
        im = imm[11:0];
        return {im, rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2,
                                          input int rs1, input int f3,
                                          input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2,
                                          input int rs1);
        logic [11:0] im;
        im = imm[11:0];
        return {im[11:5], rs2[4:0], rs1[4:0], 3'b010, im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2,
                                          input int rs1);
        logic [12:0] im;
        im = imm[12:0];
        return {im[12], im[10:5], rs2[4:0], rs1[4:0], 3'b000,
                im[4:1], im[11], 7'h63};
    endfunction

    // Consume-side scoreboard check
    always @(negedge clk) begin
        if (!reset && out_valid && ex_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_entry", {63'd0, out_valid}, 64'd0);
            end else begin
                me = sb.pop_front();
                chk("ctrl_ex", {55'd0, ctrl_ex}, {55'd0, me.ctrl});
                chk("branch_ex", {63'd0, branch_ex}, {63'd0, me.br});
                chk("pc_ex", {32'd0, pc_ex}, {32'd0, me.pc});
                chk("pc4_ex", {32'd0, pc4_ex}, {32'd0, me.pc4});
                chk("r_data1", {32'd0, r_data1}, {32'd0, me.r1});
                chk("r_data2", {32'd0, r_data2}, {32'd0, me.r2});
                chk("extended", {32'd0, extended}, {32'd0, me.ext});
                chk("rd_ex", {59'd0, rd_ex}, {59'd0, me.rd});
                chk("illegal", {63'd0, illegal}, {63'd0, me.ill});
            end
        end
    end

    task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                        input exp_t e, input bit load, output int waited);
        @(negedge clk);
        in_valid  = 1'b1;
        pipe_data = ins;
        pipe_pc   = pc;
        pipe_pc4  = pc + 32'd4;
        waited    = 0;
        #1;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else if (load) begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] ins;
    exp_t        e;
    int          w;
    logic [6:0]  rf7 [6];
    logic [2:0]  rf3 [6];
    logic [8:0]  rct [6];

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[1]  = 32'h40;
        rf[2]  = 32'h22;
        rf[3]  = 32'h203;
        rf[7]  = 32'h1111;
        rf[20] = 32'd8;

        rf7 = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00};
        rf3 = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd1, 3'd2};
        rct = '{9'b100000000, 9'b100000010, 9'b100000100,
                9'b100000110, 9'b100001000, 9'b100001010};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ctrl", {55'd0, ctrl_ex}, 64'd0);
        chk("rst_pc4", {32'd0, pc4_ex}, 64'd0);
        chk("rst_ctrl_j", {63'd0, control_j}, 64'd0);
        chk("rst_pc_j", {32'd0, pc_j}, 64'd0);
        chk("rst_r1", {32'd0, r_data1}, 64'd0);
        chk("rst_illegal", {63'd0, illegal}, 64'd0);
        reset = 1'b0;
        #1;
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

        // ADDI x12,x20,7 @400
        ins = enc_i(7, 20, 0, 12, 7'h13);
        e = mk(9'b100000001, 1'b0, ins, 32'd400, 32'd7, 5'd12, 1'b0);
        send(ins, 32'd400, e, 1'b1, w);

        // R-type ALU table
        for (int i = 0; i < 6; i++) begin
            ins = enc_r(int'(rf7[i]), i + 2, i + 1, int'(rf3[i]), 10 + i);
            e = mk(rct[i], 1'b0, ins, 32'h200 + 4 * i, 32'd0,
                   5'(10 + i), 1'b0);
            send(ins, 32'h200 + 4 * i, e, 1'b1, w);
        end

        // SD x9,-8(x2) and BEQ x1,x2,-12
        ins = enc_s(-8, 9, 2);
        e = mk(9'b000010001, 1'b0, ins, 32'h280, 32'hFFFF_FFF8,
               5'd0, 1'b0);
        send(ins, 32'h280, e, 1'b1, w);
        ins = enc_b(-12, 2, 1);
        e = mk(9'b000000000, 1'b1, ins, 32'h284, 32'hFFFF_FFF4,
               5'd0, 1'b0);
        send(ins, 32'h284, e, 1'b1, w);

        // LD x5,0(x1) then ADD x6,x5,x2: one-cycle stall
        ins = enc_i(0, 1, 2, 5, 7'h03);
        e = mk(9'b101100001, 1'b0, ins, 32'h300, 32'd0, 5'd5, 1'b0);
        send(ins, 32'h300, e, 1'b1, w);
        chk("ld_no_stall", w, 64'd0);
        ins = enc_r(0, 2, 5, 0, 6);
        e = mk(9'b100000000, 1'b0, ins, 32'h304, 32'd0, 5'd6, 1'b0);
        send(ins, 32'h304, e, 1'b1, w);
        chk("ld_use_stall", w, 64'd1);

        // JAL x1,+16 @100, then one dropped input
        ins = 32'h010000EF;
        e = mk(9'b110000000, 1'b0, ins, 32'd100, 32'd16, 5'd1, 1'b0);
        send(ins, 32'd100, e, 1'b1, w);
        chk("jal_ctrl_j", {63'd0, control_j}, 64'd1);
        chk("jal_pc_j", {32'd0, pc_j}, 64'd116);
        ins = enc_i(1, 1, 0, 9, 7'h13);
        send(ins, 32'd104, e, 1'b0, w);
        chk("jal_pulse_end", {63'd0, control_j}, 64'd0);
        chk("jal_pc_j_hold", {32'd0, pc_j}, 64'd116);

        // JALR x5,4(x3) with x3=0x203, then one dropped input
        ins = enc_i(4, 3, 0, 5, 7'h67);
        e = mk(9'b110000000, 1'b0, ins, 32'h320, 32'd4, 5'd5, 1'b0);
        send(ins, 32'h320, e, 1'b1, w);
        chk("jalr_ctrl_j", {63'd0, control_j}, 64'd1);
        chk("jalr_pc_j", {32'd0, pc_j}, 64'h206);
        ins = enc_i(2, 1, 0, 9, 7'h13);
        send(ins, 32'h324, e, 1'b0, w);
        chk("jalr_pulse_end", {63'd0, control_j}, 64'd0);

        // Write-back bypass to x7, and x0 write masking
        idle(1);
        op_write   = 1'b1;
        write_addr = 5'd7;
        write_data = 32'hDEAD;
        #1;
        chk("wb_we", {63'd0, write_pc_reg_we}, 64'd1);
        chk("wb_addr", {59'd0, write_pc_reg_addr}, 64'd7);
        chk("wb_val", {32'd0, write_pc_reg_value}, 64'hDEAD);
        ins = enc_r(0, 0, 7, 0, 8);
        e = mk(9'b100000000, 1'b0, ins, 32'h400, 32'd0, 5'd8, 1'b0);
        e.r1 = 32'hDEAD;
        send(ins, 32'h400, e, 1'b1, w);
        write_addr = 5'd0;
        #1;
        chk("wb_x0_we", {63'd0, write_pc_reg_we}, 64'd0);
        op_write = 1'b0;

        // Flush while entry held with ex_ready=0
        idle(2);
        ex_ready = 1'b0;
        ins = enc_i(1, 1, 0, 4, 7'h13);
        send(ins, 32'h500, e, 1'b0, w);
        @(negedge clk);
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_ready", {63'd0, in_ready}, 64'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        ex_ready = 1'b1;

        // Flush kills an input accepted in the same cycle
        idle(1);
        flush = 1'b1;
        ins = enc_i(3, 1, 0, 4, 7'h13);
        send(ins, 32'h504, e, 1'b0, w);
        flush = 1'b0;
        chk("flush_input", {63'd0, out_valid}, 64'd0);

        // Unknown opcode
        ins = 32'h0000_007F;
        e = mk(9'b000000000, 1'b0, ins, 32'h600, 32'd0, 5'd0, 1'b1);
        send(ins, 32'h600, e, 1'b1, w);

        idle(4);
        chk("sb_drained", sb.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
